// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multicycle CPU control FSM with retired-instruction counter.
module cpu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        neg,
    input  logic        zero,
    input  logic        mem_ack,
    output logic [3:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        aluout_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        halted,
    output logic [3:0]  state,
    output logic [15:0] retired
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EX = 4'd2, WB_ALU = 4'd3, LD_MEM = 4'd4,
        WB_LD = 4'd5, MEM_ST = 4'd6, BR_TAKE = 4'd7, BR_NOT = 4'd8,
        EX_JAL = 4'd9, WB_JAL = 4'd10, EX_JR = 4'd11, HALT = 4'd15
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q + {15'd0, pc_we};
        case (state_q)
            FETCH:   state_d = mem_ack ? DECODE : FETCH;
            DECODE:  state_d = opcode <= 4'd9  ? EX :
                               opcode == 4'd10 ? (zero ? BR_TAKE : BR_NOT) :
                               opcode == 4'd11 ? (neg ? BR_TAKE : BR_NOT) :
                               opcode == 4'd12 ? WB_JAL :
                               opcode == 4'd13 ? EX_JAL :
                               opcode == 4'd14 ? EX_JR : HALT;
            EX:      state_d = opcode == 4'd8 ? LD_MEM : opcode == 4'd9 ? MEM_ST : WB_ALU;
            LD_MEM:  state_d = mem_ack ? WB_LD : LD_MEM;
            MEM_ST:  state_d = mem_ack ? FETCH : MEM_ST;
            EX_JAL:  state_d = WB_JAL;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Every output is forced low while rst_n is asserted, whatever the state.
    always_comb begin
        alu_op    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        aluout_we = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = '0;
        halted    = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH:   begin mem_req = 1'b1; ir_we = mem_ack; end
                EX:      begin alu_op = opcode; aluout_we = 1'b1; end
                WB_ALU:  begin rf_we = 1'b1; alu_op = 4'd10; pc_we = 1'b1; end
                LD_MEM:  begin mem_req = 1'b1; addr_sel = 1'b1; mdr_we = mem_ack; end
                WB_LD:   begin rf_we = 1'b1; rf_wsel = 2'd1; alu_op = 4'd10; pc_we = 1'b1; end
                MEM_ST:  begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    alu_op   = mem_ack ? 4'd10 : 4'd0;
                    pc_we    = mem_ack;
                end
                BR_TAKE: begin alu_op = 4'd11; pc_we = 1'b1; end
                BR_NOT:  begin alu_op = 4'd10; pc_we = 1'b1; end
                EX_JAL:  begin alu_op = 4'd10; rf_we = 1'b1; rf_wsel = 2'd2; end
                WB_JAL:  begin alu_op = 4'd12; pc_we = 1'b1; end
                EX_JR:   begin alu_op = 4'd13; pc_we = 1'b1; end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: instruction-level model of cpu_ctrl checked every cycle.
module tb_cpu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, neg, zero, mem_ack;
    logic [3:0]  opcode, alu_op, state;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, aluout_we, pc_we, rf_we, halted;
    logic [1:0]  rf_wsel;
    logic [15:0] retired;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .neg(neg), .zero(zero),
        .mem_ack(mem_ack), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .aluout_we(aluout_we),
        .pc_we(pc_we), .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] REQ = 9'h100, WE = 9'h080, ASEL = 9'h040, IRW = 9'h020,
                           MDRW = 9'h010, ALUW = 9'h008, PCW = 9'h004, RFW = 9'h002,
                           HLT = 9'h001;

    typedef struct packed {
        logic        rst;
        logic [3:0]  st;
        logic [3:0]  alu;
        logic [8:0]  ctl;
        logic [1:0]  wsel;
        logic [15:0] ret;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [15:0] cnt = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          nreq = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("state", {12'd0, state}, {12'd0, cur.st});
            chk("ctl", {7'd0, mem_req, mem_we, addr_sel, ir_we, mdr_we, aluout_we, pc_we, rf_we, halted},
                {7'd0, cur.ctl});
            chk("retired", retired, cur.ret);
            if (!cur.rst) begin
                chk("alu_op", {12'd0, alu_op}, {12'd0, cur.alu});
                chk("rf_wsel", {14'd0, rf_wsel}, {14'd0, cur.wsel});
            end
        end
    end

    task automatic cyc(input logic [3:0] st, input logic [3:0] alu, input logic [8:0] ctl,
                       input logic [1:0] wsel, input logic ack);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mem_ack = ack;
        q.push_back(exp_t'{1'b0, st, alu, ctl, wsel, cnt});
        if ((ctl & PCW) != 0) cnt++;
    endtask

    task automatic do_reset(input logic [3:0] cur_st);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        q.push_back(exp_t'{1'b1, cur_st, 4'd0, 9'd0, 2'd0, cnt});
        cnt = '0;
    endtask

    task automatic idle_chk(input string name, input logic [15:0] exp);
        cyc(4'd0, 4'd0, REQ, 2'd0, 1'b0);
        #1;
        chk(name, retired, exp);
    endtask

    // fw/mw: cycles of missing mem_ack; sp: spurious mem_ack outside memory states.
    task automatic instr(input logic [3:0] op, input logic z, input logic n, input int fw,
                         input int mw, input logic sp, input logic abort);
        logic take;
        opcode = op;
        zero   = z;
        neg    = n;
        repeat (fw) cyc(4'd0, 4'd0, REQ, 2'd0, 1'b0);
        cyc(4'd0, 4'd0, REQ | IRW, 2'd0, 1'b1);
        cyc(4'd1, 4'd0, 9'd0, 2'd0, sp);
        if (op <= 4'd9) begin
            cyc(4'd2, op, ALUW, 2'd0, sp);
            if (op <= 4'd7) begin
                cyc(4'd3, 4'd10, RFW | PCW, 2'd0, sp);
            end else if (op == 4'd8) begin
                repeat (mw) cyc(4'd4, 4'd0, REQ | ASEL, 2'd0, 1'b0);
                cyc(4'd4, 4'd0, REQ | ASEL | MDRW, 2'd0, 1'b1);
                cyc(4'd5, 4'd10, RFW | PCW, 2'd1, sp);
            end else begin
                repeat (mw) cyc(4'd6, 4'd0, REQ | WE | ASEL, 2'd0, 1'b0);
                if (abort) do_reset(4'd6);
                else cyc(4'd6, 4'd10, REQ | WE | ASEL | PCW, 2'd0, 1'b1);
            end
        end else if (op <= 4'd11) begin
            take = (op == 4'd10) ? z : n;
            cyc(take ? 4'd7 : 4'd8, take ? 4'd11 : 4'd10, PCW, 2'd0, sp);
        end else if (op == 4'd12) begin
            cyc(4'd10, 4'd12, PCW, 2'd0, sp);
        end else if (op == 4'd13) begin
            cyc(4'd9, 4'd10, RFW, 2'd2, sp);
            cyc(4'd10, 4'd12, PCW, 2'd0, sp);
        end else if (op == 4'd14) begin
            cyc(4'd11, 4'd13, PCW, 2'd0, sp);
        end else begin
            repeat (100) begin
                cyc(4'd15, 4'd0, HLT, 2'd0, sp);
                #1;
                if (mem_req) nreq++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; opcode = '0; zero = 1'b0; neg = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(4'd0);
        instr(4'd0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_chk("ret_add", 16'd1);
        instr(4'd8, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);
        instr(4'd10, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        instr(4'd10, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
        instr(4'd11, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        instr(4'd11, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_chk("ret_br", 16'd6);
        for (int i = 1; i < 8; i++) instr(4'(i), 1'b0, 1'b0, i % 2, 0, 1'(i % 3 == 0), 1'b0);
        instr(4'd9, 1'b0, 1'b0, 0, 2, 1'b1, 1'b0);
        instr(4'd9, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        instr(4'd12, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        instr(4'd13, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle_chk("ret_jal", 16'd17);
        instr(4'd14, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        instr(4'd9, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1);
        idle_chk("ret_rst", 16'd0);
        // Preload the counter just below wrap instead of retiring 65534 instructions.
        @(negedge clk);
        #1;
        force dut.retired_q = 16'hFFFE;
        cnt = 16'hFFFE;
        cyc(4'd0, 4'd0, REQ, 2'd0, 1'b0);
        release dut.retired_q;
        instr(4'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        idle_chk("ret_ffff", 16'hFFFF);
        instr(4'd1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        idle_chk("ret_wrap", 16'h0000);
        instr(4'd15, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        chk("halt_no_req", 16'(nreq), 16'd0);
        chk("halted_held", {15'd0, halted}, 16'd1);
        do_reset(4'd15);
        cyc(4'd0, 4'd0, REQ, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 opcode  in  4  instruction bits [15:12], taken from the instruction register.
REQ-004 neg  in  1  ALU flag, sign of operand b.
REQ-005 zero  in  1  ALU flag, operand b equals 0.
REQ-006 mem_ack  in  1  memory completed the current request this cycle.
REQ-007 alu_op  out  4  ALU operation select.
REQ-008 mem_req  out  1  memory request, held high until mem_ack.
REQ-009 mem_we  out  1  write request; valid only while mem_req is high.
REQ-010 addr_sel  out  1  memory address source: 0 = pc, 1 = ALU result register.
REQ-011 ir_we / mdr_we / aluout_we  out  1 each  latch enables for the instruction register, memory data register and ALU result register.
REQ-012 pc_we  out  1  pc is loaded from alu out.
REQ-013 rf_we  out  1  register-file write enable.
REQ-014 rf_wsel  out  2  write-back source: 0 = ALU result register, 1 = MDR, 2 = alu out live (link to r15).
REQ-015 halted  out  1  controller is in HALT.
REQ-016 state  out  4  current state encoding, for debug.
REQ-017 retired  out  16  count of retired instructions.

Function
REQ-018 The controller SHALL be a multicycle FSM with these states and encodings: FETCH=0, DECODE=1, EX=2, WB_ALU=3, LD_MEM=4, WB_LD=5, MEM_ST=6, BR_TAKE=7, BR_NOT=8, EX_JAL=9, WB_JAL=10, EX_JR=11, HALT=15.
REQ-019 Opcode map: 0-6 add/sub/and/or/not/shl/shr; 7 ldi; 8 ld; 9 st; 10 brz; 11 brn; 12 j; 13 jal; 14 jr; 15 halt.
REQ-020 Outputs SHALL be 0 unless asserted below; when not stated, alu_op SHALL be 0.
REQ-021 FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - No mem_ack: remain in FETCH.
  - On mem_ack: ir_we=1 in the same cycle, next state DECODE.
REQ-022 DECODE transitions:
  - Opcode 0-9: go to EX.
  - Opcode 10: BR_TAKE if zero, else BR_NOT.
  - Opcode 11: BR_TAKE if neg, else BR_NOT.
  - Opcode 12: WB_JAL.
  - Opcode 13: EX_JAL.
  - Opcode 14: EX_JR.
  - Opcode 15: HALT.
REQ-023 EX: alu_op=opcode, aluout_we=1.
  - Opcode 0-7: go to WB_ALU.
  - Opcode 8: go to LD_MEM.
  - Opcode 9: go to MEM_ST.
REQ-024 WB_ALU: rf_we=1, rf_wsel=0, alu_op=10, pc_we=1; next state FETCH.
REQ-025 LD_MEM: mem_req=1, addr_sel=1.
  - No mem_ack: stay.
  - On mem_ack: mdr_we=1, next state WB_LD.
REQ-026 WB_LD: rf_we=1, rf_wsel=1, alu_op=10, pc_we=1; next state FETCH.
REQ-027 MEM_ST: mem_req=1, mem_we=1, addr_sel=1.
  - No mem_ack: stay.
  - On mem_ack: alu_op=10, pc_we=1, next state FETCH.
REQ-028 BR_TAKE: alu_op=11, pc_we=1. BR_NOT: alu_op=10, pc_we=1. Both go to FETCH.
REQ-029 EX_JAL: alu_op=10, rf_we=1, rf_wsel=2; next state WB_JAL.
REQ-030 WB_JAL: alu_op=12, pc_we=1; next state FETCH.
REQ-031 EX_JR: alu_op=13, pc_we=1; next state FETCH.
REQ-032 HALT: halted=1, no memory requests; remain in HALT until reset.
REQ-033 retired SHALL increment by 1 on every cycle with pc_we=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-034 mem_ack outside FETCH, LD_MEM or MEM_ST SHALL be ignored.
REQ-035 mem_ack in the first cycle of a request SHALL be honoured, giving single-cycle memory.
REQ-036 pc_we and rf_we SHALL never both be 1 outside WB_ALU and WB_LD.
REQ-037 mem_we SHALL never be 1 while mem_req is 0.

Reset
REQ-038 On a rising edge with rst_n=0, regardless of state or any pending mem_req:
  - state becomes FETCH;
  - retired becomes 0;
  - all enables, mem_req and halted are 0 in the cycle that rst_n is low.
REQ-039 The first FETCH request SHALL be issued in the first cycle after rst_n returns high.

Verification
REQ-040 Reset, then add with mem_ack tied 1 -> states 0,1,2,3,0; pc_we pulses once in WB_ALU with alu_op=10; retired=1.
REQ-041 ld with mem_ack delayed 3 cycles in LD_MEM -> mem_req and addr_sel=1 held for 4 cycles, then mdr_we=1, then WB_LD with rf_wsel=1.
REQ-042 brz with zero=1, then brz with zero=0 -> BR_TAKE with alu_op=11, then BR_NOT with alu_op=10.
REQ-043 jal -> EX_JAL with rf_we=1, rf_wsel=2, alu_op=10; then WB_JAL with alu_op=12, pc_we=1; retired increments once.
REQ-044 Reset asserted mid-MEM_ST while awaiting mem_ack -> mem_req=0 in the cycle rst_n is low, and state=0 after the edge; halt opcode -> halted=1 held for 100 cycles with no mem_req.
REQ-045 Preload retired to 0xFFFF by executing 65535 instructions, then one more -> retired=0x0000.
